// File: rtl/produto_escalar_feeder.sv
// produto_escalar_feeder: stream-side initiator for the produto_escalar
// dot-product accelerator. It collects 16 operand words (a0..a7, b0..b7),
// pulses start, waits for done (with timeout) and returns the 64-bit result
// over a valid/ready stream.
module produto_escalar_feeder #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [63:0] m_data,
    output logic        start,
    input  logic        done,
    input  logic [63:0] result,
    output logic [31:0] a0,
    output logic [31:0] a1,
    output logic [31:0] a2,
    output logic [31:0] a3,
    output logic [31:0] a4,
    output logic [31:0] a5,
    output logic [31:0] a6,
    output logic [31:0] a7,
    output logic [31:0] b0,
    output logic [31:0] b1,
    output logic [31:0] b2,
    output logic [31:0] b3,
    output logic [31:0] b4,
    output logic [31:0] b5,
    output logic [31:0] b6,
    output logic [31:0] b7,
    output logic        busy,
    output logic        timeout_err,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_OUT
    } state_t;

    localparam logic [15:0] TLAST = 16'(TIMEOUT - 1);

    state_t      state;
    state_t      state_n;
    logic [3:0]  wcnt;
    logic [15:0] tcnt;
    logic [31:0] ops [16];
    logic        in_hs;
    logic        wait_done;
    logic        wait_expire;

    // Next-state logic; done has priority over the timeout in WAIT.
    always_comb begin
        state_n     = state;
        in_hs       = 1'b0;
        wait_done   = 1'b0;
        wait_expire = 1'b0;
        unique case (state)
            ST_LOAD: begin
                if (s_valid && s_ready) begin
                    in_hs = 1'b1;
                    if (wcnt == 4'd15) state_n = ST_START;
                end
            end
            ST_START: state_n = ST_WAIT;
            ST_WAIT: begin
                if (done) begin
                    wait_done = 1'b1;
                    state_n   = ST_OUT;
                end else if (tcnt == TLAST) begin
                    wait_expire = 1'b1;
                    state_n     = ST_LOAD;
                end
            end
            ST_OUT: begin
                if (m_valid && m_ready) state_n = ST_LOAD;
            end
            default: state_n = ST_LOAD;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_LOAD;
        else     state <= state_n;
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_ready <= 1'b0;
            start   <= 1'b0;
            m_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            s_ready <= (state_n == ST_LOAD);
            start   <= (state_n == ST_START);
            m_valid <= (state_n == ST_OUT);
            busy    <= (state_n != ST_LOAD);
        end
    end

    // Word counter: wraps from 15 back to 0 on the final handshake.
    always_ff @(posedge clk) begin
        if (rst)        wcnt <= '0;
        else if (in_hs) wcnt <= wcnt + 4'd1;
    end

    // Timeout counter runs only while waiting and restarts at every WAIT entry.
    always_ff @(posedge clk) begin
        if (rst || state != ST_WAIT) tcnt <= '0;
        else                         tcnt <= tcnt + 16'd1;
    end

    // Operand registers keep their value until rewritten by the next load.
    always_ff @(posedge clk) begin
        if (rst)        ops <= '{default: '0};
        else if (in_hs) ops[wcnt] <= s_data;
    end

    // Result capture: bit-exact copy of the accelerator result.
    always_ff @(posedge clk) begin
        if (rst)            m_data <= '0;
        else if (wait_done) m_data <= result;
    end

    // Sticky timeout flag; a timeout outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)              timeout_err <= 1'b0;
        else if (wait_expire) timeout_err <= 1'b1;
        else if (err_clr)     timeout_err <= 1'b0;
    end

    assign a0 = ops[0];
    assign a1 = ops[1];
    assign a2 = ops[2];
    assign a3 = ops[3];
    assign a4 = ops[4];
    assign a5 = ops[5];
    assign a6 = ops[6];
    assign a7 = ops[7];
    assign b0 = ops[8];
    assign b1 = ops[9];
    assign b2 = ops[10];
    assign b3 = ops[11];
    assign b4 = ops[12];
    assign b5 = ops[13];
    assign b6 = ops[14];
    assign b7 = ops[15];

endmodule

// File: tb/tb_produto_escalar_feeder.sv
// Testbench for produto_escalar_feeder: accelerator model, timestamp-based
// reference model with a per-cycle compare, and directed vectors.
module tb_produto_escalar_feeder;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_data;
    logic        start;
    logic        done;
    logic [63:0] result;
    logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7;
    logic [31:0] b0, b1, b2, b3, b4, b5, b6, b7;
    logic        busy;
    logic        timeout_err;
    logic        err_clr;

    always #5 clk = ~clk;

    produto_escalar_feeder #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .start(start), .done(done), .result(result),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3), .b4(b4), .b5(b5), .b6(b6), .b7(b7),
        .busy(busy), .timeout_err(timeout_err), .err_clr(err_clr)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] dot16(input logic [31:0] w [16]);
        logic signed [63:0] acc;
        logic signed [63:0] x;
        logic signed [63:0] y;
        acc = '0;
        for (int i = 0; i < 8; i++) begin
            x = $signed(w[i]);
            y = $signed(w[i+8]);
            acc += x * y;
        end
        return acc;
    endfunction

    logic [31:0] dut_ops [16];
    always_comb begin
        dut_ops[0]  = a0; dut_ops[1]  = a1; dut_ops[2]  = a2; dut_ops[3]  = a3;
        dut_ops[4]  = a4; dut_ops[5]  = a5; dut_ops[6]  = a6; dut_ops[7]  = a7;
        dut_ops[8]  = b0; dut_ops[9]  = b1; dut_ops[10] = b2; dut_ops[11] = b3;
        dut_ops[12] = b4; dut_ops[13] = b5; dut_ops[14] = b6; dut_ops[15] = b7;
    end

    // Accelerator model: done pulses acc_delay cycles after start is seen.
    bit          acc_en    = 1'b1;
    int          acc_delay = 9;
    int          acc_cnt   = 0;
    logic [63:0] acc_res;
    initial begin
        done   = 1'b0;
        result = '0;
        forever begin
            @(posedge clk);
            #1;
            done   = 1'b0;
            result = {$urandom, $urandom};
            if (acc_cnt > 0) begin
                acc_cnt--;
                if (acc_cnt == 0) begin
                    done   = 1'b1;
                    result = acc_res;
                end
            end else if (start === 1'b1 && acc_en) begin
                acc_cnt = acc_delay;
                acc_res = dot16(dut_ops);
            end
        end
    end

    // Reference model: tracks the transaction by timestamps of its events.
    logic        e_sready, e_start, e_mvalid, e_busy, e_err;
    logic [63:0] e_mdata;
    logic [31:0] e_ops [16];
    logic [63:0] exp_res;
    longint      cyc = 0;
    longint      T   = 0;
    int          nw  = 0;
    bit          tx, have, tmo;
    bit          started = 1'b0;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                tx = 0; have = 0; nw = 0;
                for (int i = 0; i < 16; i++) e_ops[i] = '0;
                e_mdata = '0; e_err = 1'b0;
                e_sready = 1'b0; e_start = 1'b0; e_mvalid = 1'b0; e_busy = 1'b0;
            end else begin
                tmo = 0;
                if (have && m_ready) have = 0;
                if (e_sready && s_valid) begin
                    e_ops[nw] = s_data;
                    nw++;
                    if (nw == 16) begin
                        nw = 0; tx = 1; T = cyc;
                        exp_res = dot16(e_ops);
                    end
                end else if (tx && cyc >= T + 2) begin
                    if (done) begin
                        tx = 0; have = 1; e_mdata = exp_res;
                    end else if (cyc == T + 1 + TO) begin
                        tx = 0; tmo = 1;
                    end
                end
                if (tmo)          e_err = 1'b1;
                else if (err_clr) e_err = 1'b0;
                e_sready = !tx && !have;
                e_start  = tx && (cyc == T);
                e_mvalid = have;
                e_busy   = tx || have;
            end
            cyc++;
            started = 1'b1;
        end
    end

    // Per-cycle compare against the model.
    int bad;
    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("s_ready", s_ready, e_sready);
                check("start", start, e_start);
                check("m_valid", m_valid, e_mvalid);
                check("busy", busy, e_busy);
                check("timeout_err", timeout_err, e_err);
                check("m_data", m_data, e_mdata);
                checks++;
                bad = -1;
                for (int i = 0; i < 16; i++) if (dut_ops[i] !== e_ops[i]) bad = i;
                if (bad >= 0) begin
                    failures++;
                    $display("FAIL operands: word %0d got %h expected %h", bad, dut_ops[bad], e_ops[bad]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gappy);
        int n;
        bit hs;
        n  = 0;
        hs = 0;
        while (!hs) begin
            if (gappy && $urandom_range(0, 2) == 0) begin
                s_valid = 1'b0;
                s_data  = $urandom;
            end else begin
                s_valid = 1'b1;
                s_data  = w;
            end
            hs = s_valid && s_ready;
            tick();
            n++;
            if (!hs && n > 100) begin
                checks++; failures++;
                $display("FAIL load_stall: s_ready never accepted word %h", w);
                hs = 1;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic load_vec(input logic [31:0] w [16], input bit gappy);
        for (int i = 0; i < 16; i++) send_word(w[i], gappy);
    endtask

    task automatic recv(input string name, input logic [63:0] exp, input int hold);
        int n;
        n = 0;
        while (m_valid !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check({name, "_mvalid"}, m_valid, 1'b1);
        for (int i = 0; i < hold; i++) begin
            check({name, "_hold"}, m_valid, 1'b1);
            tick();
        end
        m_ready = 1'b1;
        check(name, m_data, exp);
        tick();
        m_ready = 1'b0;
        check({name, "_sready_after"}, s_ready, 1'b1);
        check({name, "_mvalid_after"}, m_valid, 1'b0);
    endtask

    logic [31:0] v1 [16];
    logic [31:0] v2 [16];
    logic [31:0] v3 [16];
    logic [31:0] v4 [16];
    logic [31:0] v5 [16];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            v1[i] = 32'(i + 1); v1[i+8] = 32'(i + 1);
            v2[i] = '0;         v2[i+8] = '0;
            v3[i] = '1;         v3[i+8] = 32'd3;
            v5[i] = 32'd2;      v5[i+8] = 32'(i + 1);
        end
        v2[0] = 32'h8000_0000;
        v2[8] = 32'h8000_0000;
        v4 = '{32'd5, -32'sd2, 32'd7, 32'd0, 32'd100, -32'sd100, 32'd3, 32'd1,
               32'd2, 32'd3, -32'sd4, 32'd9, 32'd1, 32'd1, 32'd6, -32'sd7};

        rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        check("rst_sready", s_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mdata", m_data, 64'd0);
        check("rst_err", timeout_err, 1'b0);
        rst = 1'b0;
        tick();
        check("sready_rise", s_ready, 1'b1);

        // a=b=1..8 back-to-back
        load_vec(v1, 1'b0);
        check("start_pulse", start, 1'b1);
        tick();
        check("start_single", start, 1'b0);
        recv("res_204", 64'd204, 3);

        // signed extremes, then an all-rewrite vector
        load_vec(v2, 1'b0);
        recv("res_min_sq", 64'h4000_0000_0000_0000, 0);
        load_vec(v3, 1'b0);
        recv("res_neg24", 64'hFFFF_FFFF_FFFF_FFE8, 0);

        // gappy load, slow consumer, then the next vector
        load_vec(v4, 1'b1);
        recv("res_neg13", 64'hFFFF_FFFF_FFFF_FFF3, 5);
        load_vec(v5, 1'b1);
        recv("res_72", 64'd72, 2);

        // timeout with done tied low
        acc_en = 1'b0;
        load_vec(v1, 1'b0);
        repeat (16) tick();
        check("tmo_not_yet", timeout_err, 1'b0);
        tick();
        check("tmo_set", timeout_err, 1'b1);
        check("tmo_sready", s_ready, 1'b1);
        check("tmo_busy", busy, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("err_clr", timeout_err, 1'b0);

        // clear coincident with a second timeout: set wins
        load_vec(v2, 1'b0);
        repeat (16) tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("tmo_set_wins", timeout_err, 1'b1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;

        // done in the final timeout cycle
        acc_en = 1'b1;
        acc_delay = 16;
        load_vec(v3, 1'b0);
        recv("res_late_done", 64'hFFFF_FFFF_FFFF_FFE8, 0);
        check("late_done_no_err", timeout_err, 1'b0);
        acc_delay = 9;

        // reset after 9 words
        for (int i = 0; i < 9; i++) send_word(v4[i], 1'b0);
        rst = 1'b1;
        tick();
        check("rst_load_a0", a0, 32'd0);
        check("rst_load_sready", s_ready, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        load_vec(v5, 1'b0);
        recv("res_after_rst", 64'd72, 0);

        // reset three cycles into WAIT; the late done must be ignored
        load_vec(v1, 1'b0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("rst_wait_busy", busy, 1'b0);
        check("rst_wait_mdata", m_data, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        load_vec(v3, 1'b0);
        recv("res_after_wait_rst", 64'hFFFF_FFFF_FFFF_FFE8, 0);

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/produto_escalar_feeder.md
# produto_escalar_feeder

Stream-side initiator for the `produto_escalar` dot-product accelerator. It accepts 16 signed 32-bit words over a valid/ready input stream (a0..a7 then b0..b7) and drives the accelerator's operand and start ports. It then waits for `done` and returns the 64-bit result over a valid/ready output stream. It sits between a DMA/stream fabric and the accelerator, so software no longer needs 17 CSR writes per dot product.

## Interface
- `TIMEOUT`, 64: maximum cycles spent in WAIT before the transaction is abandoned; legal range 16..65535.

- `clk`  in  1  single clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `s_valid`  in  1  input word valid.
- `s_ready`  out  1  input word accepted when `s_valid && s_ready`.
- `s_data`  in  32  signed operand word.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  result consumed when `m_valid && m_ready`.
- `m_data`  out  64  signed dot-product result.
- `start`  out  1  one-cycle start pulse to the accelerator.
- `done`  in  1  accelerator completion pulse.
- `result`  in  64  accelerator result, valid while `done`=1.
- `a0`..`a7`, `b0`..`b7`  out  32 each  registered operands to the accelerator.
- `busy`  out  1  high in START/WAIT/OUT.
- `timeout_err`  out  1  sticky timeout flag.
- `err_clr`  in  1  clears `timeout_err`.

## Operation
- State machine:
  - LOAD
    - `s_ready`=1.
    - A 4-bit word counter `wcnt` selects the destination register: 0..7 → a0..a7, 8..15 → b0..b7.
    - On each handshake the addressed register is written and `wcnt` increments.
    - The handshake at `wcnt`=15 moves the FSM to START and resets `wcnt` to 0.
  - START
    - `start`=1 for exactly this cycle; the FSM then moves to WAIT.
  - WAIT
    - Timeout counter `tcnt` starts at 0 on entry and increments every cycle.
    - If `done`=1: capture `result` into `m_data` and go to OUT.
    - Otherwise, if `tcnt`==`TIMEOUT`-1: set `timeout_err`, discard the transaction and go to LOAD.
  - OUT
    - `m_valid`=1 and `m_data` held stable until the handshake, then go to LOAD.
- Operand registers are not cleared between transactions. Each register holds its value until it is rewritten by the next LOAD.
- `m_data` is a bit-exact copy of `result`. The block adds no arithmetic; overflow wrap is the accelerator's.
- Boundary and priority rules:
  - `done` and timeout in the same cycle: `done` wins and the result is delivered; `timeout_err` is not set.
  - `done` outside WAIT: ignored.
  - `s_valid` outside LOAD: ignored, since `s_ready`=0 there.
  - `err_clr` and a timeout in the same cycle: set wins.
  - `err_clr` at any other time: clears `timeout_err` on the next edge.
- Reset at any state, including mid-LOAD or mid-WAIT:
  - `wcnt` and `tcnt` return to 0 and the FSM returns to LOAD.
  - Any in-flight accelerator result is dropped; a late `done` is ignored.
- Reset values:
  - `s_ready`=0, `m_valid`=0, `start`=0, `busy`=0, `timeout_err`=0.
  - `m_data`=0 and all a*/b* registers =0.

## Timing
- All outputs are registered.
- `s_ready` rises in the first cycle after `rst` deasserts.
- Load throughput is one word per cycle: 16 words take 16 cycles minimum, with gaps allowed.
- Last input handshake at cycle T:
  - `s_ready`=0 from T+1.
  - `start`=1 in cycle T+1 only.
  - WAIT begins at T+2.
- The accelerator raises `done` about 9 cycles after sampling `start`. If `done` is seen at cycle D, `m_valid`=1 at D+1.
- Output handshake at cycle H: `m_valid`=0 and `s_ready`=1 at H+1.
- Timeout: with no `done`, `timeout_err`=1 and `s_ready`=1 at T+2+`TIMEOUT`.
- `busy` = 1 from T+1 through the output handshake cycle or the timeout cycle.

## Test plan
- a=1..8, b=1..8, streamed back-to-back with the accelerator model → `start` is a single pulse one cycle after the 16th word; `m_data`=204; `m_valid` stays high until `m_ready`.
- a0=b0=0x8000_0000, all other words 0 → `m_data`=0x4000_0000_0000_0000. Then a=all 0xFFFF_FFFF, b=all 3 → `m_data`=-24 (0xFFFF_FFFF_FFFF_FFE8).
- `s_valid` toggled randomly during load and `m_ready` held low 5 cycles after `m_valid` → `m_data` stable throughout and `s_ready`=0 during START/WAIT/OUT. The next vector loads correctly, with no stale operand leak when every word is rewritten.
- `TIMEOUT`=16, `done` tied 0 → `timeout_err`=1 exactly 16 cycles after WAIT entry, `m_valid` never rises, FSM back in LOAD. `err_clr` pulse → `timeout_err`=0 next cycle. `err_clr` coincident with a second timeout → `timeout_err` stays 1.
- `done` forced in the final timeout cycle → result delivered and `timeout_err` stays 0.
- `rst` asserted after 9 words loaded, and separately 3 cycles into WAIT → all outputs at reset values. After `rst` deasserts, a fresh 16-word load produces the correct result, and a late `done` from the aborted run is ignored.
